// File: rtl/ej32_pkg.sv
// Shared constants and bus payload types for the eJ32 memory bus stage.
package ej32_pkg;

  localparam int unsigned BUS_ASZ    = 17;
  localparam int unsigned DW         = 8;
  localparam int unsigned OBUF_DEF   = 'h1400;
  localparam int unsigned OBSZ_DEF   = 'h400;
  localparam int unsigned FDEPTH_DEF = 16;

  typedef struct packed {
    logic [BUS_ASZ-1:0] addr;
    logic [DW-1:0]      data;
    logic               we;
  } mem_req_t;

  // True when addr falls inside [base, base+size).
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && (addr < (base + size));
  endfunction

endpackage

// File: rtl/ej32_tx_fifo.sv
// Byte FIFO feeding the console port; power-of-2 depth with wrap-bit pointers.
module ej32_tx_fifo
  import ej32_pkg::*;
#(
  parameter int unsigned DEPTH = FDEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;

  // Pointer registers; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/ej32_mem_bus.sv
// eJ32 memory bus stage: PC/LS address mux onto a byte SRAM, console TX snoop
// of output-buffer writes, and core stall when the TX FIFO is full.
module ej32_mem_bus
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ    = BUS_ASZ,
  parameter int unsigned OBUF   = OBUF_DEF,
  parameter int unsigned OBSZ   = OBSZ_DEF,
  parameter int unsigned FDEPTH = FDEPTH_DEF,
  localparam int unsigned CW    = $clog2(FDEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ASZ-1:0] pc_i,
  input  logic           ls_asel_i,
  input  logic [ASZ-1:0] ls_addr_i,
  input  logic [DW-1:0]  ls_data_i,
  input  logic           ls_dwe_i,
  output logic [DW-1:0]  data_o,
  output logic           stall_o,
  output logic [ASZ-1:0] mem_addr_o,
  output logic [DW-1:0]  mem_data_o,
  output logic           mem_we_o,
  input  logic [DW-1:0]  mem_data_i,
  output logic [DW-1:0]  tx_data_o,
  output logic           tx_valid_o,
  input  logic           tx_ready_i,
  output logic [CW-1:0]  tx_cnt_o
);

  logic          ob_hit;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [DW-1:0] hold_q;
  mem_req_t      req;

  assign ob_hit = ls_asel_i & ls_dwe_i
                & in_window(32'(ls_addr_i), 32'(OBUF), 32'(OBSZ));

  assign tx_valid_o = ~empty;
  assign pop        = tx_valid_o & tx_ready_i;

  // A pop in the same cycle frees a slot, so a full FIFO only stalls without one.
  // Reset gating makes the stall and any pending write vanish asynchronously.
  assign stall_o = rst & ob_hit & full & ~pop;
  assign push    = rst & ob_hit & ~stall_o;

  always_comb begin
    req      = '0;
    req.addr = BUS_ASZ'(ls_asel_i ? ls_addr_i : pc_i);
    req.data = ls_data_i;
    req.we   = rst & ls_asel_i & ls_dwe_i & ~stall_o;
  end

  assign mem_addr_o = ASZ'(req.addr);
  assign mem_data_o = req.data;
  assign mem_we_o   = req.we;

  // Last byte the core saw; replayed while the core is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else if (!stall_o) begin
      hold_q <= mem_data_i;
    end
  end

  assign data_o = (stall_o || !rst) ? hold_q : mem_data_i;

  ej32_tx_fifo #(
    .DEPTH (FDEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ls_data_i),
    .pop   (pop),
    .dout  (tx_data_o),
    .full  (full),
    .empty (empty),
    .count (tx_cnt_o)
  );

endmodule

// File: tb/tb_ej32_mem_bus.sv
// Self-checking bench for ej32_mem_bus with a behavioural byte SRAM and a TX scoreboard.
module tb_ej32_mem_bus;
  import ej32_pkg::*;

  localparam int unsigned ASZ = 17;
  localparam int unsigned CW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [ASZ-1:0] pc_i;
  logic           ls_asel_i;
  logic [ASZ-1:0] ls_addr_i;
  logic [7:0]     ls_data_i;
  logic           ls_dwe_i;
  logic [7:0]     data_o;
  logic           stall_o;
  logic [ASZ-1:0] mem_addr_o;
  logic [7:0]     mem_data_o;
  logic           mem_we_o;
  logic [7:0]     mem_data_i;
  logic [7:0]     tx_data_o;
  logic           tx_valid_o;
  logic           tx_ready_i;
  logic [CW-1:0]  tx_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  ej32_mem_bus dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ls_asel_i  (ls_asel_i),
    .ls_addr_i  (ls_addr_i),
    .ls_data_i  (ls_data_i),
    .ls_dwe_i   (ls_dwe_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_we_o   (mem_we_o),
    .mem_data_i (mem_data_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_cnt_o   (tx_cnt_o)
  );

  // SRAM model: unwritten bytes read back a fixed pattern of their address.
  logic [7:0] sram [0:(1<<ASZ)-1];
  bit         wv   [0:(1<<ASZ)-1];
  logic [7:0] rdata_q;

  function automatic logic [7:0] init_byte(input logic [ASZ-1:0] a);
    if (a == 17'h00100) return 8'hA7;
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 8'h00;
    end else begin
      if (mem_we_o) begin
        sram[mem_addr_o] <= mem_data_o;
        wv[mem_addr_o]   <= 1'b1;
      end
      rdata_q <= wv[mem_addr_o] ? sram[mem_addr_o] : init_byte(mem_addr_o);
    end
  end
  assign mem_data_i = rdata_q;

  // Advance one cycle; a console handshake seen this cycle is scored first.
  task automatic tick();
    logic [7:0] exp;
    if (rst && tx_valid_o && tx_ready_i) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %h, none expected", tx_data_o);
      end else begin
        exp = sb.pop_front();
        if (tx_data_o !== exp) begin
          n_err++;
          $display("FAIL tx_order: got %h, want %h", tx_data_o, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    tick();
    tx_ready_i = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!tx_valid_o) break;
      tick();
    end
    tick();
    tx_ready_i = 1'b0;
    n_vec++;
    if (tx_valid_o !== 1'b0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: valid=%b left=%0d, want valid=0 left=0", tx_valid_o, sb.size());
    end
  endtask

  task automatic ls_write(input logic [ASZ-1:0] a, input logic [7:0] d);
    ls_asel_i = 1'b1;
    ls_addr_i = a;
    ls_data_i = d;
    ls_dwe_i  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_i = '0; tx_ready_i = 1'b0;
    ls_write(17'h01400, 8'h11);
    @(negedge clk);
    n_vec += 5;
    if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tx_valid_o); end
    if (tx_cnt_o !== 5'd0)   begin n_err++; $display("FAIL reset_cnt: got %0d want 0", tx_cnt_o); end
    if (stall_o !== 1'b0)    begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    if (mem_we_o !== 1'b0)   begin n_err++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    if (data_o !== 8'h00)    begin n_err++; $display("FAIL reset_data: got %h want 00", data_o); end
    @(posedge clk); #1;
    ls_dwe_i = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    tick();
    ls_asel_i = 1'b0; pc_i = 17'h00100;
    ls_addr_i = 17'h01400; ls_dwe_i = 1'b1;
    @(negedge clk);
    n_vec += 3;
    if (mem_addr_o !== 17'h00100) begin n_err++; $display("FAIL fetch_addr: got %h want 00100", mem_addr_o); end
    if (mem_we_o !== 1'b0)        begin n_err++; $display("FAIL pc_write_ignored: got %b want 0", mem_we_o); end
    if (stall_o !== 1'b0)         begin n_err++; $display("FAIL pc_write_stall: got %b want 0", stall_o); end
    tick();
    ls_asel_i = 1'b1; ls_addr_i = 17'h00200; ls_dwe_i = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (data_o !== 8'hA7)         begin n_err++; $display("FAIL fetch_data: got %h want a7", data_o); end
    if (mem_addr_o !== 17'h00200) begin n_err++; $display("FAIL ls_addr: got %h want 00200", mem_addr_o); end
    if (tx_cnt_o !== 5'd0)        begin n_err++; $display("FAIL pc_write_push: got %0d want 0", tx_cnt_o); end
    tick();
    @(negedge clk);
    n_vec++;
    if (data_o !== 8'h02) begin n_err++; $display("FAIL ls_read_data: got %h want 02", data_o); end
  endtask

  task automatic test_single_write();
    tick();
    ls_write(17'h01400, 8'h41);
    @(negedge clk);
    n_vec++;
    if (mem_we_o !== 1'b1) begin n_err++; $display("FAIL ob_we: got %b want 1", mem_we_o); end
    sb.push_back(8'h41);
    tick();
    ls_dwe_i = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL ob_valid: got %b want 1", tx_valid_o); end
    if (tx_data_o !== 8'h41) begin n_err++; $display("FAIL ob_data: got %h want 41", tx_data_o); end
    if (tx_cnt_o !== 5'd1)   begin n_err++; $display("FAIL ob_cnt: got %0d want 1", tx_cnt_o); end
    drain();
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 16; i++) begin
      tick();
      ls_write(17'h01400 + 17'(i), 8'h50 + 8'(i));
      @(negedge clk);
      n_vec++;
      if (stall_o !== 1'b0) begin n_err++; $display("FAIL fill_stall_%0d: got %b want 0", i, stall_o); end
      sb.push_back(8'h50 + 8'(i));
    end
    tick();
    ls_write(17'h01410, 8'h60);
    @(negedge clk);
    n_vec += 3;
    if (stall_o !== 1'b1)  begin n_err++; $display("FAIL full_stall: got %b want 1", stall_o); end
    if (mem_we_o !== 1'b0) begin n_err++; $display("FAIL full_we: got %b want 0", mem_we_o); end
    if (data_o !== 8'h1A)  begin n_err++; $display("FAIL stall_hold: got %h want 1a", data_o); end
    tick();
    tx_ready_i = 1'b1;
    @(negedge clk);
    n_vec += 2;
    if (stall_o !== 1'b0)  begin n_err++; $display("FAIL pop_unstall: got %b want 0", stall_o); end
    if (mem_we_o !== 1'b1) begin n_err++; $display("FAIL pop_unstall_we: got %b want 1", mem_we_o); end
    sb.push_back(8'h60);
    tick();
    ls_dwe_i = 1'b0; tx_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (tx_cnt_o !== 5'd16) begin n_err++; $display("FAIL refill_cnt: got %0d want 16", tx_cnt_o); end
  endtask

  task automatic test_outside_window();
    tick();
    ls_write(17'h01800, 8'h77);
    @(negedge clk);
    n_vec += 2;
    if (stall_o !== 1'b0)  begin n_err++; $display("FAIL out_stall: got %b want 0", stall_o); end
    if (mem_we_o !== 1'b1) begin n_err++; $display("FAIL out_we: got %b want 1", mem_we_o); end
    tick();
    ls_dwe_i = 1'b0;
    @(negedge clk);
    n_vec += 2;
    if (tx_cnt_o !== 5'd16)       begin n_err++; $display("FAIL out_cnt: got %0d want 16", tx_cnt_o); end
    if (sram[17'h01800] !== 8'h77) begin n_err++; $display("FAIL out_sram: got %h want 77", sram[17'h01800]); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      tick();
      ls_write(17'h01400 + 17'(i), 8'h30 + 8'(i));
      tx_ready_i = 1'b0;
      @(negedge clk);
      sb.push_back(8'h30 + 8'(i));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      ls_write(17'h01405 + 17'(k), 8'h35 + 8'(k));
      tx_ready_i = 1'b1;
      @(negedge clk);
      n_vec += 2;
      if (tx_cnt_o !== 5'd5) begin n_err++; $display("FAIL b2b_cnt_%0d: got %0d want 5", k, tx_cnt_o); end
      if (stall_o !== 1'b0)  begin n_err++; $display("FAIL b2b_stall_%0d: got %b want 0", k, stall_o); end
      sb.push_back(8'h35 + 8'(k));
    end
    tick();
    ls_dwe_i = 1'b0; tx_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (tx_cnt_o !== 5'd5) begin n_err++; $display("FAIL b2b_cnt_end: got %0d want 5", tx_cnt_o); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 16; i++) begin
      tick();
      ls_write(17'h01400 + 17'(i), 8'h80 + 8'(i));
      @(negedge clk);
      sb.push_back(8'h80 + 8'(i));
    end
    tick();
    ls_write(17'h01410, 8'h99);
    @(negedge clk);
    n_vec++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall: got %b want 1", stall_o); end
    #2 rst = 1'b0;
    #1;
    n_vec += 4;
    if (stall_o !== 1'b0)    begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_o); end
    if (mem_we_o !== 1'b0)   begin n_err++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
    if (tx_cnt_o !== 5'd0)   begin n_err++; $display("FAIL rst_cnt: got %0d want 0", tx_cnt_o); end
    if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", tx_valid_o); end
    sb.delete();
    tick();
    ls_dwe_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (sram[17'h01410] !== 8'h60) begin n_err++; $display("FAIL rst_no_write: got %h want 60", sram[17'h01410]); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_single_write();
    test_fill_stall();
    test_outside_window();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
